dcache_req_responder: RTL
=========================

DCACHE_REQ_RESPONDER -- requirements
Module: dcache_req_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 64-bit backing words (power of two).
REQ-002 Parameter LD_LATENCY, default 2, cycles from load tag phase to response (1..7).
REQ-003 Parameters INDEX_W, default 12, and TAG_W, default 44, address split widths.
REQ-004 clk_i  in  1  clock; rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 ld_valid_i  in  1  load index phase; ld_index_i  in  INDEX_W  index.
REQ-006 ld_tag_i  in  TAG_W  tag; ld_tag_valid_i  in  1  load tag phase.
REQ-007 ld_size_i  in  2  size; ld_kill_i  in  1  abort the in-flight load.
REQ-008 ld_gnt_o  out  1  index accepted; ld_rvalid_o  out  1  load data valid; ld_rdata_o  out  64  load data.
REQ-009 st_valid_i  in  1; st_index_i  in  INDEX_W; st_tag_i  in  TAG_W; st_wdata_i  in  64; st_be_i  in  8  byte enables.
REQ-010 st_gnt_o  out  1  store accepted and written.
REQ-011 amo_valid_i  in  1; amo_op_i  in  amo_t; amo_size_i  in  2; amo_addr_i  in  64; amo_operand_i  in  64.
REQ-012 amo_ack_o  out  1  atomic complete; amo_result_o  out  64  result.

Function
REQ-013 Physical address = {tag, index}; word select = address[3 +: log2(MEM_WORDS)]; upper bits ignored (wrap-around).
REQ-014 States: IDLE, LD_TAG, LD_PIPE, AMO_EXEC, AMO_RESP.
REQ-015 IDLE arbitration when requests coincide: AMO > store > load; losers see no grant and must hold.
REQ-016 Load: in IDLE with ld_valid_i and no higher-priority request, ld_gnt_o = 1 same cycle (combinational); latch index; -> LD_TAG.
REQ-017 LD_TAG: on ld_tag_valid_i, latch tag, load counter with LD_LATENCY-1, -> LD_PIPE; otherwise wait indefinitely.
REQ-018 LD_PIPE: counter decrements each cycle; at 0, ld_rvalid_o = 1 for exactly one cycle with the full 64-bit word (no size shifting), -> IDLE.
REQ-019 ld_kill_i in LD_TAG or LD_PIPE -> IDLE next cycle; no ld_rvalid_o pulse; kill has priority over same-cycle ld_tag_valid_i.
REQ-020 Store: in IDLE with st_valid_i and no AMO, st_gnt_o = 1 same cycle; bytes with st_be_i set are written at the clock edge; stay IDLE.
REQ-021 Stores arriving outside IDLE are not granted.
REQ-022 AMO: in IDLE with amo_valid_i, latch op, size, address, operand -> AMO_EXEC; read old word, compute, write back -> AMO_RESP; amo_ack_o = 1 one cycle in AMO_RESP -> IDLE; ack is 2 cycles after acceptance.
REQ-023 amo_size_i = 2'b10: operate on 32-bit half selected by address bit 2; result sign-extended old half; only that half written. 2'b11: full 64 bits.
REQ-024 Ops: SWAP, ADD (wraps at operand width), AND, OR, XOR, MAX/MIN signed, MAXU/MINU unsigned; amo_result_o = old value.
REQ-025 LR: returns old value, sets reservation {valid, word address}; no write.
REQ-026 SC: if reservation valid and address matches, write operand, result 0; else no write, result 1; reservation cleared in both cases.
REQ-027 Any granted store or AMO write to the reserved word clears the reservation.
REQ-028 AMO_NONE: treated as a no-op, acked with result 0.
REQ-029 amo_result_o holds its last value until the next ack; ld_rdata_o holds until the next rvalid.

Reset
REQ-030 On rstn_i low: state IDLE; all grant, valid and ack outputs 0; ld_rdata_o and amo_result_o 0; reservation invalid; counter 0.
REQ-031 Reset mid-operation aborts it without a response; backing memory contents are not reset.
REQ-032 First request is accepted in the first cycle after rstn_i deasserts.

Verification
REQ-033 Store 0x1122334455667788 to word 5 with be 0xFF, then load with tag 1 cycle after grant, LD_LATENCY=2 -> rvalid 2 cycles after tag_valid, data 0x1122334455667788.
REQ-034 Store be 0x0F with wdata 0xAAAAAAAABBBBBBBB over 0x1122334455667788 -> subsequent load returns 0x11223344BBBBBBBB.
REQ-035 Same-cycle amo_valid, st_valid and ld_valid in IDLE -> only the AMO is accepted; the store is granted the cycle after amo_ack; the load after that.
REQ-036 AMO ADD word at addr 0x4 (upper half) with old 0x7FFFFFFF_00000000 and operand 1 -> result 0x000000007FFFFFFF, memory 0x80000000_00000000.
REQ-037 LR to addr A, store to A, SC to A -> SC result 1, no write; LR to A then SC to A -> result 0, write.
REQ-038 ld_kill in LD_PIPE -> no rvalid; next load is granted the following cycle; rstn_i low in AMO_EXEC -> no ack, all outputs 0.

Source files
------------

// File: rtl/dcache_req_responder.sv
// dcache_req_responder
// Memory-side responder for a data cache request port. It owns a small
// 64-bit-word backing store and serves three request classes:
//   - loads  : index phase (ld_valid_i/ld_index_i, granted on ld_gnt_o),
//              then tag phase (ld_tag_valid_i/ld_tag_i), then the response
//              (ld_rvalid_o/ld_rdata_o) LD_LATENCY cycles after the tag.
//              ld_kill_i abandons a load before its response.
//   - stores : st_valid_i/st_index_i/st_tag_i/st_wdata_i/st_be_i, granted
//              (st_gnt_o) and byte-written in the same cycle, IDLE only.
//   - atomics: amo_valid_i/amo_op_i/amo_size_i/amo_addr_i/amo_operand_i,
//              completed with amo_ack_o/amo_result_o two cycles after
//              acceptance. LR/SC use a single-word reservation.
// Arbitration in IDLE: AMO > store > load. clk_i clock, rstn_i async
// active-low reset (the backing memory itself is not reset).
module dcache_req_responder #(
  parameter int MEM_WORDS  = 256,
  parameter int LD_LATENCY = 2,
  parameter int INDEX_W    = 12,
  parameter int TAG_W      = 44
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               ld_valid_i,
  input  logic [INDEX_W-1:0] ld_index_i,
  input  logic [TAG_W-1:0]   ld_tag_i,
  input  logic               ld_tag_valid_i,
  input  logic [1:0]         ld_size_i,
  input  logic               ld_kill_i,
  output logic               ld_gnt_o,
  output logic               ld_rvalid_o,
  output logic [63:0]        ld_rdata_o,
  input  logic               st_valid_i,
  input  logic [INDEX_W-1:0] st_index_i,
  input  logic [TAG_W-1:0]   st_tag_i,
  input  logic [63:0]        st_wdata_i,
  input  logic [7:0]         st_be_i,
  output logic               st_gnt_o,
  input  logic               amo_valid_i,
  input  logic [3:0]         amo_op_i,
  input  logic [1:0]         amo_size_i,
  input  logic [63:0]        amo_addr_i,
  input  logic [63:0]        amo_operand_i,
  output logic               amo_ack_o,
  output logic [63:0]        amo_result_o
);
  localparam int AW   = $clog2(MEM_WORDS);
  localparam int PA_W = TAG_W + INDEX_W;

  // amo_t encoding
  localparam logic [3:0] AMO_NONE = 4'd0,  AMO_LR   = 4'd1,  AMO_SC   = 4'd2;
  localparam logic [3:0] AMO_SWAP = 4'd3,  AMO_ADD  = 4'd4,  AMO_AND  = 4'd5;
  localparam logic [3:0] AMO_OR   = 4'd6,  AMO_XOR  = 4'd7,  AMO_MAX  = 4'd8;
  localparam logic [3:0] AMO_MAXU = 4'd9,  AMO_MIN  = 4'd10, AMO_MINU = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_LD_TAG, S_LD_PIPE, S_AMO_EXEC, S_AMO_RESP} state_t;

  state_t             r_state;
  logic [63:0]        r_mem [MEM_WORDS];
  logic [INDEX_W-1:0] r_ld_index;
  logic [TAG_W-1:0]   r_ld_tag;
  logic [2:0]         r_cnt;
  logic               r_ld_rvalid;
  logic [63:0]        r_ld_rdata;
  logic [3:0]         r_amo_op;
  logic [1:0]         r_amo_size;
  logic [AW-1:0]      r_amo_word;
  logic               r_amo_hi;
  logic [63:0]        r_amo_operand;
  logic               r_amo_ack;
  logic [63:0]        r_amo_result;
  logic               r_resv_valid;
  logic [AW-1:0]      r_resv_addr;

  // Address decode: word select from the physical address, upper bits wrap.
  logic [PA_W-1:0] w_ld_pa, w_tag_pa, w_st_pa;
  logic [AW-1:0]   w_ld_word, w_tag_word, w_st_word;
  assign w_ld_pa    = {r_ld_tag, r_ld_index};
  assign w_tag_pa   = {ld_tag_i, r_ld_index};
  assign w_st_pa    = {st_tag_i, st_index_i};
  assign w_ld_word  = w_ld_pa[3 +: AW];
  assign w_tag_word = w_tag_pa[3 +: AW];
  assign w_st_word  = w_st_pa[3 +: AW];

  logic w_unused;
  assign w_unused = ^{ld_size_i, amo_addr_i[63:3+AW], amo_addr_i[1:0],
                      w_ld_pa[PA_W-1:3+AW], w_ld_pa[2:0], w_tag_pa[PA_W-1:3+AW],
                      w_tag_pa[2:0], w_st_pa[PA_W-1:3+AW], w_st_pa[2:0]};

  // Grants are combinational; gated by rstn_i so nothing is granted in reset.
  logic w_idle, w_st_gnt, w_ld_gnt;
  assign w_idle   = rstn_i && (r_state == S_IDLE);
  assign w_st_gnt = w_idle && st_valid_i && !amo_valid_i;
  assign w_ld_gnt = w_idle && ld_valid_i && !amo_valid_i && !st_valid_i;

  // AMO datapath. Word-sized ops work on extended copies of the selected
  // half so one 64-bit compare/add serves both sizes.
  logic        w_is_w, w_lt_s, w_lt_u, w_we;
  logic [31:0] w_old_half;
  logic [63:0] w_old, w_a_s, w_a_u, w_b_s, w_b_u, w_new, w_res, w_merged;
  assign w_old      = r_mem[r_amo_word];
  assign w_is_w     = (r_amo_size == 2'b10);
  assign w_old_half = r_amo_hi ? w_old[63:32] : w_old[31:0];
  assign w_a_s      = w_is_w ? {{32{w_old_half[31]}}, w_old_half} : w_old;
  assign w_a_u      = w_is_w ? {32'b0, w_old_half} : w_old;
  assign w_b_s      = w_is_w ? {{32{r_amo_operand[31]}}, r_amo_operand[31:0]} : r_amo_operand;
  assign w_b_u      = w_is_w ? {32'b0, r_amo_operand[31:0]} : r_amo_operand;
  assign w_lt_s     = $signed(w_a_s) < $signed(w_b_s);
  assign w_lt_u     = w_a_u < w_b_u;

  always_comb begin
    w_new = w_a_u;
    w_we  = 1'b0;
    w_res = w_a_s;
    case (r_amo_op)
      AMO_LR:   ;
      AMO_SC: begin
        if (r_resv_valid && (r_resv_addr == r_amo_word)) begin
          w_new = w_b_u;
          w_we  = 1'b1;
          w_res = 64'd0;
        end else begin
          w_res = 64'd1;
        end
      end
      AMO_SWAP: begin w_new = w_b_u;                   w_we = 1'b1; end
      AMO_ADD:  begin w_new = w_a_u + w_b_u;           w_we = 1'b1; end
      AMO_AND:  begin w_new = w_a_u & w_b_u;           w_we = 1'b1; end
      AMO_OR:   begin w_new = w_a_u | w_b_u;           w_we = 1'b1; end
      AMO_XOR:  begin w_new = w_a_u ^ w_b_u;           w_we = 1'b1; end
      AMO_MAX:  begin w_new = w_lt_s ? w_b_u : w_a_u;  w_we = 1'b1; end
      AMO_MIN:  begin w_new = w_lt_s ? w_a_u : w_b_u;  w_we = 1'b1; end
      AMO_MAXU: begin w_new = w_lt_u ? w_b_u : w_a_u;  w_we = 1'b1; end
      AMO_MINU: begin w_new = w_lt_u ? w_a_u : w_b_u;  w_we = 1'b1; end
      default:  w_res = 64'd0;  // AMO_NONE and unused codes: no-op
    endcase
  end

  // Only the addressed half changes for word-sized ops.
  assign w_merged = !w_is_w ? w_new :
                    (r_amo_hi ? {w_new[31:0], w_old[31:0]} : {w_old[63:32], w_new[31:0]});

  logic w_amo_we;
  assign w_amo_we = (r_state == S_AMO_EXEC) && w_we;

  // Backing memory: no reset. Store and AMO writes never share a cycle.
  always_ff @(posedge clk_i) begin
    if (w_amo_we) r_mem[r_amo_word] <= w_merged;
    for (int b = 0; b < 8; b++) begin
      if (w_st_gnt && st_be_i[b]) r_mem[w_st_word][8*b +: 8] <= st_wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_ld_index    <= '0;
      r_ld_tag      <= '0;
      r_cnt         <= 3'd0;
      r_ld_rvalid   <= 1'b0;
      r_ld_rdata    <= 64'd0;
      r_amo_op      <= AMO_NONE;
      r_amo_size    <= 2'b00;
      r_amo_word    <= '0;
      r_amo_hi      <= 1'b0;
      r_amo_operand <= 64'd0;
      r_amo_ack     <= 1'b0;
      r_amo_result  <= 64'd0;
      r_resv_valid  <= 1'b0;
      r_resv_addr   <= '0;
    end else begin
      r_ld_rvalid <= 1'b0;
      r_amo_ack   <= 1'b0;
      if (w_st_gnt && (w_st_word == r_resv_addr)) r_resv_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (amo_valid_i) begin
            r_amo_op      <= amo_op_i;
            r_amo_size    <= amo_size_i;
            r_amo_word    <= amo_addr_i[3 +: AW];
            r_amo_hi      <= amo_addr_i[2];
            r_amo_operand <= amo_operand_i;
            r_state       <= S_AMO_EXEC;
          end else if (w_ld_gnt) begin
            r_ld_index <= ld_index_i;
            r_state    <= S_LD_TAG;
          end
        end
        S_LD_TAG: begin
          if (ld_kill_i) begin
            r_state <= S_IDLE;
          end else if (ld_tag_valid_i) begin
            r_ld_tag <= ld_tag_i;
            r_cnt    <= 3'(LD_LATENCY - 1);
            r_state  <= S_LD_PIPE;
            // The response is presented in the LD_PIPE cycle where the
            // counter reads 0, so with latency 1 data is fetched right here.
            if (LD_LATENCY == 1) begin
              r_ld_rvalid <= 1'b1;
              r_ld_rdata  <= r_mem[w_tag_word];
            end
          end
        end
        S_LD_PIPE: begin
          // A kill can only suppress a response not yet presented.
          if (ld_kill_i || (r_cnt == 3'd0)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_ld_rvalid <= 1'b1;
              r_ld_rdata  <= r_mem[w_ld_word];
            end
          end
        end
        S_AMO_EXEC: begin
          r_amo_result <= w_res;
          r_amo_ack    <= 1'b1;
          r_state      <= S_AMO_RESP;
          if (r_amo_op == AMO_LR) begin
            r_resv_valid <= 1'b1;
            r_resv_addr  <= r_amo_word;
          end else if (r_amo_op == AMO_SC) begin
            r_resv_valid <= 1'b0;
          end else if (w_we && (r_amo_word == r_resv_addr)) begin
            r_resv_valid <= 1'b0;
          end
        end
        S_AMO_RESP: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_gnt_o     = w_ld_gnt;
  assign st_gnt_o     = w_st_gnt;
  assign ld_rvalid_o  = r_ld_rvalid;
  assign ld_rdata_o   = r_ld_rdata;
  assign amo_ack_o    = r_amo_ack;
  assign amo_result_o = r_amo_result;
endmodule
